// File: rtl/pipelined_control_unit.sv
// Decode and control pipeline (ID/EX/MEM/WB) with load-use stall and EX jump redirect/flush.
// Define CU_PERF_CNT_EN to add saturating stall_cnt/flush_cnt cycle counters.
`default_nettype none

module pipelined_control_unit #(
    parameter int OPCODE_W   = 6,
    parameter int ALU_CTRL_W = 5,
    parameter int REG_W      = 4,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [OPCODE_W-1:0]   id_opcode,
    input  logic [REG_W-1:0]      id_rs1,
    input  logic [REG_W-1:0]      id_rs2,
    input  logic [REG_W-1:0]      id_rd,
    input  logic                  ex_zero,
    input  logic                  ex_neg,
    output logic [1:0]            id_imm_src,
    output logic [ALU_CTRL_W-1:0] ex_alu_control,
    output logic                  ex_alu_src,
    output logic [REG_W-1:0]      ex_rd,
    output logic                  mem_mem_write,
    output logic                  wb_reg_write,
    output logic [1:0]            wb_mem_to_reg,
    output logic [REG_W-1:0]      wb_rd,
    output logic                  pc_src,
    output logic                  stall,
    output logic                  flush,
`ifdef CU_PERF_CNT_EN
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt,
`endif
    output logic                  illegal
);

    logic [5:0] op_lo;
    logic       op_hi_zero;

    logic       d_legal;
    logic [1:0] d_imm;
    logic [4:0] d_alu;
    logic [1:0] d_m2r;
    logic       d_mw;
    logic       d_rw;
    logic       d_asrc;
    logic       d_jump;
    logic       d_load;
    logic       d_use1;
    logic       d_use2;

    logic [4:0]       ex_alu_q;
    logic             ex_asrc_q;
    logic [REG_W-1:0] ex_rd_q;
    logic             ex_mw_q;
    logic             ex_rw_q;
    logic [1:0]       ex_m2r_q;
    logic             ex_jump_q;
    logic             ex_load_q;

    logic             mem_mw_q;
    logic             mem_rw_q;
    logic [1:0]       mem_m2r_q;
    logic [REG_W-1:0] mem_rd_q;

    logic             wb_rw_q;
    logic [1:0]       wb_m2r_q;
    logic [REG_W-1:0] wb_rd_q;

    logic jump_cond;
    logic taken;
    logic load_use;
    logic issue;

    assign op_lo      = id_opcode[5:0];
    assign op_hi_zero = ((id_opcode >> 6) == '0);

    always_comb begin
        d_legal = 1'b1;
        d_imm   = 2'b00;
        d_alu   = 5'b00000;
        d_m2r   = 2'b00;
        d_mw    = 1'b0;
        d_rw    = 1'b0;
        d_asrc  = 1'b0;
        d_jump  = 1'b0;
        d_load  = 1'b0;
        d_use1  = 1'b0;
        d_use2  = 1'b0;
        if (op_hi_zero) begin
            case (op_lo)
                6'h01, 6'h02, 6'h03: begin
                    d_alu = {3'b000, op_lo[1:0]};
                    d_rw = 1'b1; d_use1 = 1'b1; d_use2 = 1'b1;
                end
                6'h09, 6'h0A, 6'h0B: begin
                    d_alu = {3'b000, op_lo[1:0]};
                    d_rw = 1'b1; d_asrc = 1'b1; d_use1 = 1'b1;
                end
                6'h04: begin
                    d_alu = 5'b00100; d_m2r = 2'b10;
                    d_rw = 1'b1; d_use1 = 1'b1;
                end
                6'h0C: begin
                    d_alu = 5'b00100; d_m2r = 2'b10;
                    d_rw = 1'b1; d_asrc = 1'b1;
                end
                6'h11, 6'h12, 6'h13: begin
                    d_alu = {2'b01, op_lo[2:0]};
                    d_rw = 1'b1; d_use1 = 1'b1; d_use2 = 1'b1;
                end
                6'h14: begin
                    d_alu = 5'b01100;
                    d_rw = 1'b1; d_use1 = 1'b1;
                end
                6'h19, 6'h1A: begin
                    d_imm = 2'b01; d_alu = {2'b01, op_lo[2:0]};
                    d_rw = 1'b1; d_asrc = 1'b1; d_use1 = 1'b1;
                end
                6'h29: begin
                    d_imm = 2'b10; d_alu = 5'b10001; d_m2r = 2'b01;
                    d_rw = 1'b1; d_asrc = 1'b1; d_use1 = 1'b1; d_load = 1'b1;
                end
                6'h2A: begin
                    d_imm = 2'b10; d_alu = 5'b10010;
                    d_rw = 1'b1; d_asrc = 1'b1; d_use1 = 1'b1;
                end
                6'h2B: begin
                    d_imm = 2'b10; d_alu = 5'b10011;
                    d_mw = 1'b1; d_asrc = 1'b1; d_use1 = 1'b1; d_use2 = 1'b1;
                end
                6'h38, 6'h39, 6'h3A, 6'h3B, 6'h3C, 6'h3D, 6'h3E: begin
                    d_imm = 2'b11; d_alu = {2'b11, op_lo[2:0]};
                    d_asrc = 1'b1; d_jump = 1'b1;
                end
                default: d_legal = 1'b0;
            endcase
        end else begin
            d_legal = 1'b0;
        end
    end

    // Jump flavour is the low three bits of the jump ALU code (JMP=0 .. JLE=6).
    always_comb begin
        jump_cond = 1'b0;
        case (ex_alu_q[2:0])
            3'd0:    jump_cond = 1'b1;
            3'd1:    jump_cond = ex_zero;
            3'd2:    jump_cond = ~ex_zero;
            3'd3:    jump_cond = ~ex_zero & ~ex_neg;
            3'd4:    jump_cond = ~ex_neg;
            3'd5:    jump_cond = ex_neg;
            3'd6:    jump_cond = ex_neg | ex_zero;
            default: jump_cond = 1'b0;
        endcase
    end

    assign taken    = ex_jump_q & jump_cond;
    assign load_use = ex_load_q & id_valid &
                      ((d_use1 & (id_rs1 == ex_rd_q)) | (d_use2 & (id_rs2 == ex_rd_q)));
    assign issue    = id_valid & d_legal & ~stall & ~taken;

    assign pc_src     = taken;
    assign flush      = taken;
    assign stall      = load_use & ~taken;
    assign illegal    = id_valid & ~d_legal;
    assign id_imm_src = d_imm;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_alu_q  <= '0;
            ex_asrc_q <= 1'b0;
            ex_rd_q   <= '0;
            ex_mw_q   <= 1'b0;
            ex_rw_q   <= 1'b0;
            ex_m2r_q  <= '0;
            ex_jump_q <= 1'b0;
            ex_load_q <= 1'b0;
        end else if (issue) begin
            ex_alu_q  <= d_alu;
            ex_asrc_q <= d_asrc;
            ex_rd_q   <= id_rd;
            ex_mw_q   <= d_mw;
            ex_rw_q   <= d_rw;
            ex_m2r_q  <= d_m2r;
            ex_jump_q <= d_jump;
            ex_load_q <= d_load;
        end else begin
            ex_alu_q  <= '0;
            ex_asrc_q <= 1'b0;
            ex_rd_q   <= '0;
            ex_mw_q   <= 1'b0;
            ex_rw_q   <= 1'b0;
            ex_m2r_q  <= '0;
            ex_jump_q <= 1'b0;
            ex_load_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_mw_q  <= 1'b0;
            mem_rw_q  <= 1'b0;
            mem_m2r_q <= '0;
            mem_rd_q  <= '0;
            wb_rw_q   <= 1'b0;
            wb_m2r_q  <= '0;
            wb_rd_q   <= '0;
        end else begin
            mem_mw_q  <= ex_mw_q;
            mem_rw_q  <= ex_rw_q;
            mem_m2r_q <= ex_m2r_q;
            mem_rd_q  <= ex_rd_q;
            wb_rw_q   <= mem_rw_q;
            wb_m2r_q  <= mem_m2r_q;
            wb_rd_q   <= mem_rd_q;
        end
    end

    assign ex_alu_control = ALU_CTRL_W'(ex_alu_q);
    assign ex_alu_src     = ex_asrc_q;
    assign ex_rd          = ex_rd_q;
    assign mem_mem_write  = mem_mw_q;
    assign wb_reg_write   = wb_rw_q;
    assign wb_mem_to_reg  = wb_m2r_q;
    assign wb_rd          = wb_rd_q;

`ifdef CU_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
            if (flush && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end
`endif

endmodule

`default_nettype wire
